clock_set_ctrl: RTL
===================

Name: clock_set_ctrl

Overview:
Control block for the 24-hour timekeeping datapath: HH:MM:SS registers driving six HEX digits.
- Generates the 1 Hz advance tick.
- Runs the key-driven set-time state machine: mode key steps hour → minute → second → run; inc key bumps the selected field.
- Issues a one-cycle load strobe with the edited time.
- Muxes edited or live time to the display and drives blink masks for the field being edited.

Parameters:
TICK_DIV, 50000000, clk cycles per tick pulse (≥2)
BLINK_DIV, 12500000, clk cycles per blink phase toggle (≥1)

Ports:
clk  in  1  system clock
rst  in  1  reset: synchronous, active-high
key_mode  in  1  raw mode pushbutton, active-low
key_inc  in  1  raw increment pushbutton, active-low
cur_hour  in  5  live hour from timekeeper
cur_min  in  6  live minute
cur_sec  in  6  live second
tick  out  1  one-cycle advance pulse to timekeeper
load  out  1  one-cycle strobe; timekeeper takes load_* values
load_hour / load_min / load_sec  out  5/6/6  edited time
mode  out  2  0 RUN, 1 SET_H, 2 SET_M, 3 SET_S
disp_hour / disp_min / disp_sec  out  5/6/6  values for the HEX digit pairs
blank  out  3  bit2 hour pair, bit1 minute pair, bit0 second pair; 1 = blank

Behaviour:
- Reset values:
  - mode=RUN; tick=0; load=0; load_*=0; blank=000.
  - Prescaler=0; blink counter and phase=0.
  - Key synchronizer flops=1 (released).
- Keys:
  - Each key passes a 2-flop synchronizer, then falling-edge detection, giving a 1-cycle press pulse.
  - Pin-to-action latency is 3 clk.
  - Bounce filtering is not this block's job.
- Prescaler:
  - Counts 0..TICK_DIV-1 in RUN only.
  - tick=1 in the cycle the count equals TICK_DIV-1; the count returns to 0 on the next cycle.
  - Held at 0 in every SET state, so time is paused while editing.
  - After return to RUN, the first tick comes exactly TICK_DIV cycles after the load cycle.
- FSM on mode press: RUN→SET_H→SET_M→SET_S→RUN.
  - RUN→SET_H: edit_h/m/s are captured from cur_* in the transition cycle.
  - SET_S→RUN: load=1 for that one cycle, load_* = edit values; load_* hold afterwards.
- Inc press in SET_x adds 1 to the selected field only; no carry into other fields.
  - Hour 23→0; minute/second 59→0.
  - Captured values above the maximum also wrap to 0 on inc.
  - Inc press in RUN is ignored.
- Mode and inc press in the same cycle: mode wins, inc is dropped.
- Display mux: disp_* = cur_* in RUN, edit_* in SET states; combinational.
- Blink:
  - In SET_x, the blink counter toggles phase every BLINK_DIV cycles.
  - The blank bit of the active field = phase; other bits are 0.
  - Phase and counter clear on entry to each SET state and on every inc press, so the digit is visible immediately.
  - blank=000 in RUN.
- rst mid-edit: edits are discarded, no load, return to RUN.

Optional Feature:
CLOCK_SET_ALARM_EN
- Defined:
  - Adds inputs alm_hour (5) and alm_min (6), and output alarm (1).
  - alarm is set in RUN on the cycle cur_hour==alm_hour, cur_min==alm_min and cur_sec==0.
  - Cleared by an inc press in RUN, a mode press, or rst.
  - Does not re-arm until the minute changes.
- Undefined: none of these ports exist; inc press in RUN is ignored.

Decomposition:
- Shared package clock_pkg:
  - mode encoding constants (MODE_RUN, MODE_SET_H, MODE_SET_M, MODE_SET_S);
  - HOUR_MAX=23, MIN_MAX=59;
  - field widths HOUR_W=5, MIN_W=6.
- One sub-module: key_edge (synchronizer plus falling-edge pulse), instantiated twice.
- BCD splitting and segment decode stay in the existing display path.

Test Plan:
1. TICK_DIV=4, rst released, no keys → tick high at cycles 4, 8, 12 after release, each exactly 1 cycle; mode=0; blank=000.
2. cur=15:00:00, mode press → mode=1 three cycles later, disp_hour=15, no tick; 9 inc presses → disp_hour 16…23, then 0.
3. Sequence: hour set to 7, minute captured 59 plus inc →0, second 30, mode press in SET_S → load=1 for one cycle with 7/0/30; mode=0; next tick TICK_DIV cycles later.
4. mode and inc pressed the same cycle in SET_M → mode=3, edit_m unchanged.
5. BLINK_DIV=2 in SET_H → blank toggles 100/000 every 2 cycles; inc press forces 000 next cycle; rst asserted in SET_M → mode=0, blank=000, load never pulses.
6. CLOCK_SET_ALARM_EN defined, alm=07:00, cur steps 06:59:59→07:00:00 → alarm=1; inc press → alarm=0, stays 0 through 07:00:59.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: shared mode encoding, field widths and limits for the HH:MM:SS
// timekeeping datapath and its set-time controller.
package clock_pkg;

    localparam int HOUR_W   = 5;
    localparam int MIN_W    = 6;
    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_SET_H = 2'd1,
        MODE_SET_M = 2'd2,
        MODE_SET_S = 2'd3
    } mode_e;

    // Field increment with no carry; anything at or above max_v wraps to 0.
    function automatic logic [MIN_W-1:0] wrap_inc(input logic [MIN_W-1:0] v,
                                                  input logic [MIN_W-1:0] max_v);
        return (v >= max_v) ? '0 : v + 1'b1;
    endfunction

endpackage

// File: rtl/key_edge.sv
// key_edge: two-flop synchronizer for an active-low pushbutton followed by
// falling-edge detection, yielding a one-cycle press pulse.
module key_edge (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        press   = prev_q & ~sync2_q;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: 1 Hz tick prescaler, key-driven set-time FSM, load strobe,
// display mux and blink masks. Define CLOCK_SET_ALARM_EN to add the alarm.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV  = 50000000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_mode,
    input  logic              key_inc,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [MIN_W-1:0]  cur_sec,
`ifdef CLOCK_SET_ALARM_EN
    input  logic [HOUR_W-1:0] alm_hour,
    input  logic [MIN_W-1:0]  alm_min,
    output logic              alarm,
`endif
    output logic              tick,
    output logic              load,
    output logic [HOUR_W-1:0] load_hour,
    output logic [MIN_W-1:0]  load_min,
    output logic [MIN_W-1:0]  load_sec,
    output logic [1:0]        mode,
    output logic [HOUR_W-1:0] disp_hour,
    output logic [MIN_W-1:0]  disp_min,
    output logic [MIN_W-1:0]  disp_sec,
    output logic [2:0]        blank
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic mode_press, inc_press;

    mode_e             state_q, state_d;
    logic [HOUR_W-1:0] edit_hour_q, edit_hour_d;
    logic [MIN_W-1:0]  edit_min_q,  edit_min_d;
    logic [MIN_W-1:0]  edit_sec_q,  edit_sec_d;
    logic              load_q,      load_d;
    logic [HOUR_W-1:0] load_hour_q, load_hour_d;
    logic [MIN_W-1:0]  load_min_q,  load_min_d;
    logic [MIN_W-1:0]  load_sec_q,  load_sec_d;
    logic [TW-1:0]     presc_q,     presc_d;
    logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
    logic              phase_q,     phase_d;

    key_edge u_key_mode (.clk(clk), .rst(rst), .key_n(key_mode), .press(mode_press));
    key_edge u_key_inc  (.clk(clk), .rst(rst), .key_n(key_inc),  .press(inc_press));

    always_comb begin
        // NOTE: every signal gets a default first so no path through the block infers a latch.
        state_d     = state_q;
        edit_hour_d = edit_hour_q;
        edit_min_d  = edit_min_q;
        edit_sec_d  = edit_sec_q;
        load_d      = 1'b0;
        load_hour_d = load_hour_q;
        load_min_d  = load_min_q;
        load_sec_d  = load_sec_q;

        // Mode press takes priority; a simultaneous inc press is dropped.
        unique case (state_q)
            MODE_RUN: begin
                if (mode_press) begin
                    state_d     = MODE_SET_H;
                    edit_hour_d = cur_hour;
                    edit_min_d  = cur_min;
                    edit_sec_d  = cur_sec;
                end
            end
            MODE_SET_H: begin
                if (mode_press)
                    state_d = MODE_SET_M;
                else if (inc_press)
                    edit_hour_d = HOUR_W'(wrap_inc(MIN_W'(edit_hour_q), MIN_W'(HOUR_MAX)));
            end
            MODE_SET_M: begin
                if (mode_press)
                    state_d = MODE_SET_S;
                else if (inc_press)
                    edit_min_d = wrap_inc(edit_min_q, MIN_W'(MIN_MAX));
            end
            MODE_SET_S: begin
                if (mode_press) begin
                    state_d     = MODE_RUN;
                    load_d      = 1'b1;
                    load_hour_d = edit_hour_q;
                    load_min_d  = edit_min_q;
                    load_sec_d  = edit_sec_q;
                end else if (inc_press) begin
                    edit_sec_d = wrap_inc(edit_sec_q, MIN_W'(MIN_MAX));
                end
            end
        endcase

        // Held through the load cycle so the first tick lands TICK_DIV cycles after it.
        tick = (state_q == MODE_RUN) && (presc_q == TICK_LAST);
        if ((state_q != MODE_RUN) || load_q || tick)
            presc_d = '0;
        else
            presc_d = presc_q + 1'b1;

        if ((state_q == MODE_RUN) || mode_press || inc_press) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
            phase_d     = phase_q;
        end

        blank     = 3'b000;
        disp_hour = cur_hour;
        disp_min  = cur_min;
        disp_sec  = cur_sec;
        unique case (state_q)
            MODE_RUN:   blank = 3'b000;
            MODE_SET_H: blank = {phase_q, 2'b00};
            MODE_SET_M: blank = {1'b0, phase_q, 1'b0};
            MODE_SET_S: blank = {2'b00, phase_q};
        endcase
        if (state_q != MODE_RUN) begin
            disp_hour = edit_hour_q;
            disp_min  = edit_min_q;
            disp_sec  = edit_sec_q;
        end

        mode      = state_q;
        load      = load_q;
        load_hour = load_hour_q;
        load_min  = load_min_q;
        load_sec  = load_sec_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MODE_RUN;
            edit_hour_q <= '0;
            edit_min_q  <= '0;
            edit_sec_q  <= '0;
            load_q      <= 1'b0;
            load_hour_q <= '0;
            load_min_q  <= '0;
            load_sec_q  <= '0;
            presc_q     <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            edit_hour_q <= edit_hour_d;
            edit_min_q  <= edit_min_d;
            edit_sec_q  <= edit_sec_d;
            load_q      <= load_d;
            load_hour_q <= load_hour_d;
            load_min_q  <= load_min_d;
            load_sec_q  <= load_sec_d;
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

`ifdef CLOCK_SET_ALARM_EN
    logic alarm_q, alarm_d;
    logic armed_q, armed_d;
    logic alm_match;

    // Armed again only once the live time leaves the alarm minute.
    always_comb begin
        alm_match = (cur_hour == alm_hour) && (cur_min == alm_min);
        alarm_d   = alarm_q;
        armed_d   = armed_q;
        if (!alm_match)
            armed_d = 1'b1;
        if ((state_q == MODE_RUN) && alm_match && (cur_sec == '0) && armed_q) begin
            alarm_d = 1'b1;
            armed_d = 1'b0;
        end
        if (mode_press || ((state_q == MODE_RUN) && inc_press))
            alarm_d = 1'b0;
        alarm = alarm_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_q <= 1'b0;
            armed_q <= 1'b1;
        end else begin
            alarm_q <= alarm_d;
            armed_q <= armed_d;
        end
    end
`endif

endmodule
